// File: rtl/btb_pkg.sv
// Shared encodings, constants and helpers for the BTB/RAS predictor.
// prio_first is used by both the lookup match and the replacement victim search.
package btb_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    // Stored addresses are word addresses (pc[31:2]).
    localparam int ADDR_W = 30;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; taps name register bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int PRIO_MAX = 256;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } prio_t;

    function automatic prio_t prio_first(input logic [PRIO_MAX-1:0] vec);
        prio_t r;
        r.found = 1'b0;
        r.idx   = '0;
        // Walk downwards so the lowest set bit is the last one to land.
        for (int i = PRIO_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 8'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btb_ras_pred_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// pop on empty is ignored, and a simultaneous push wins over pop.
module ras_circ
    import btb_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_W-1:0]    push_addr,
    output logic [ADDR_W-1:0]    top,
    output logic [RAS_PTR_W:0]   count
);

    localparam logic [RAS_PTR_W:0] FULL_COUNT = (RAS_PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0]    stack_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_PTR_W-1:0] top_ptr;
    logic                 do_pop;

    assign top_ptr = ptr - 1'b1;
    assign top     = stack_mem[top_ptr];
    assign do_pop  = pop && !push && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (count != FULL_COUNT) begin
                count <= count + 1'b1;
            end
        end else if (do_pop) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Storage is never cleared; only the pointer and occupancy are.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_mem[ptr] <= push_addr;
        end
    end

endmodule

// File: rtl/btb_ras_pred.sv
// Branch target buffer with typed entries, saturating direction counters and
// an attached return-address stack. One-cycle lookup, resolve-time update.
module btb_ras_pred
    import btb_pkg::*;
#(
    parameter int BTB_NUM   = 32,
    parameter int IDX_W     = $clog2(BTB_NUM),
    parameter int RAS_DEPTH = 8,
    parameter int RAS_PTR_W = $clog2(RAS_DEPTH),
    parameter int CTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_en,
    input  logic [31:0]          fetch_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [IDX_W-1:0]     pred_index,
    output logic [1:0]           pred_type,
    input  logic                 upd_en,
    input  logic [31:0]          upd_pc,
    input  logic [IDX_W-1:0]     upd_index,
    input  logic [1:0]           upd_type,
    input  logic                 upd_add,
    input  logic                 upd_target_err,
    input  logic                 upd_dir,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 ras_push,
    input  logic                 ras_pop,
    output logic [RAS_PTR_W:0]   ras_count
);

    localparam logic [CTR_W-1:0] CTR_WEAK_T = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};

    // Entry storage: only the valid bits are reset.
    logic [BTB_NUM-1:0] valid;
    logic [ADDR_W-1:0]  tag_mem  [BTB_NUM];
    logic [ADDR_W-1:0]  tgt_mem  [BTB_NUM];
    logic [1:0]         type_mem [BTB_NUM];
    logic [CTR_W-1:0]   ctr_mem  [BTB_NUM];

    logic               fetch_en_r;
    logic [ADDR_W-1:0]  fetch_tag_r;
    logic [7:0]         lfsr;

    logic [BTB_NUM-1:0]  match_vec;
    logic [BTB_NUM-1:0]  inv_vec;
    logic [BTB_NUM-1:0]  zero_vec;
    logic [PRIO_MAX-1:0] match_ext;
    logic [PRIO_MAX-1:0] inv_ext;
    logic [PRIO_MAX-1:0] zero_ext;
    prio_t               hit_p;
    prio_t               inv_p;
    prio_t               zero_p;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   repl_idx;
    logic [CTR_W-1:0]   ctr_cur;
    logic [CTR_W-1:0]   ctr_next;

    logic [ADDR_W-1:0]  ras_top;
    logic [ADDR_W-1:0]  ras_push_addr;
    logic               unused_bits;

    assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0],
                           hit_p, inv_p, zero_p};

    // Lookup stage register; fetch_en=0 holds the last PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_en_r  <= 1'b0;
            fetch_tag_r <= '0;
        end else begin
            fetch_en_r <= fetch_en;
            if (fetch_en) begin
                fetch_tag_r <= fetch_pc[31:2];
            end
        end
    end

    always_comb begin
        match_vec = '0;
        inv_vec   = '0;
        zero_vec  = '0;
        for (int i = 0; i < BTB_NUM; i++) begin
            match_vec[i] = valid[i] && (tag_mem[i] == fetch_tag_r);
            inv_vec[i]   = !valid[i];
            zero_vec[i]  = valid[i] && (type_mem[i] == BR_COND) && (ctr_mem[i] == '0);
        end
    end

    always_comb begin
        match_ext = '0;
        inv_ext   = '0;
        zero_ext  = '0;
        match_ext[BTB_NUM-1:0] = match_vec;
        inv_ext[BTB_NUM-1:0]   = inv_vec;
        zero_ext[BTB_NUM-1:0]  = zero_vec;
        hit_p  = prio_first(match_ext);
        inv_p  = prio_first(inv_ext);
        zero_p = prio_first(zero_ext);
    end

    assign hit     = fetch_en_r && hit_p.found;
    assign hit_idx = hit_p.idx[IDX_W-1:0];

    always_comb begin
        if (inv_p.found) begin
            repl_idx = inv_p.idx[IDX_W-1:0];
        end else if (zero_p.found) begin
            repl_idx = zero_p.idx[IDX_W-1:0];
        end else begin
            repl_idx = lfsr[IDX_W-1:0];
        end
    end

    // Prediction outputs are all-zero whenever there is no hit.
    always_comb begin
        pred_valid  = hit;
        pred_taken  = 1'b0;
        pred_target = '0;
        pred_index  = '0;
        pred_type   = '0;
        if (hit) begin
            pred_index  = hit_idx;
            pred_type   = type_mem[hit_idx];
            pred_target = {tgt_mem[hit_idx], 2'b00};
            case (br_type_e'(type_mem[hit_idx]))
                BR_COND: pred_taken = ctr_mem[hit_idx][CTR_W-1];
                BR_JUMP, BR_CALL: pred_taken = 1'b1;
                BR_RET: begin
                    if (ras_count != '0) begin
                        pred_taken  = 1'b1;
                        pred_target = {ras_top, 2'b00};
                    end
                end
                default: pred_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        ctr_cur  = ctr_mem[upd_index];
        ctr_next = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_next = ctr_cur + 1'b1;
            end
        end else if (ctr_cur != '0) begin
            ctr_next = ctr_cur - 1'b1;
        end
    end

    // upd_en qualifies every update field and ras_push/ras_pop; there is no
    // back-pressure, each strobed cycle is consumed at the next clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (upd_en && upd_add) begin
            valid[repl_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en && !reset) begin
            if (upd_add) begin
                tag_mem[repl_idx]  <= upd_pc[31:2];
                tgt_mem[repl_idx]  <= upd_target[31:2];
                type_mem[repl_idx] <= upd_type;
                ctr_mem[repl_idx]  <= CTR_WEAK_T;
            end else if (upd_target_err) begin
                tgt_mem[upd_index]  <= upd_target[31:2];
                type_mem[upd_index] <= upd_type;
                ctr_mem[upd_index]  <= CTR_WEAK_T;
            end else if (upd_dir && (upd_type == BR_COND)) begin
                ctr_mem[upd_index] <= ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Return address is the word after the call instruction.
    assign ras_push_addr = upd_pc[31:2] + 30'd1;

    ras_circ #(
        .RAS_DEPTH (RAS_DEPTH),
        .RAS_PTR_W (RAS_PTR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (upd_en && ras_push),
        .pop       (upd_en && ras_pop),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: doc/btb_ras_pred.md
Name: btb_ras_pred

Overview:
- Parametrised next-generation branch target buffer with an integrated circular return-address stack.
- Sits between IF (lookup) and ID/EX (resolve/update).
- Each entry carries a branch type: conditional, jump, call or return.
  - Returns predict from the RAS top; conditionals predict from an N-bit saturating counter.
- Replacement order: invalid entry first, then an entry whose counter is zero, then LFSR pseudo-random.

Parameters:
- BTB_NUM, 32, number of BTB entries; power of 2, range 4..256.
- IDX_W, $clog2(BTB_NUM), entry index width.
- RAS_DEPTH, 8, RAS entries; power of 2, minimum 2.
- RAS_PTR_W, $clog2(RAS_DEPTH), RAS pointer width.
- CTR_W, 2, direction counter width; minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  lookup request.
- fetch_pc  in  32  lookup PC.
- pred_valid  out  1  lookup hit, valid one cycle after fetch_en.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted target, bits [1:0] = 0.
- pred_index  out  IDX_W  index of the hit entry.
- pred_type  out  2  type of the hit entry: 00 cond, 01 jump, 10 call, 11 return.
- upd_en  in  1  resolve update strobe.
- upd_pc  in  32  PC of the resolved branch.
- upd_index  in  IDX_W  entry index carried with the prediction.
- upd_type  in  2  resolved branch type.
- upd_add  in  1  allocate a new entry (previous lookup missed).
- upd_target_err  in  1  hit entry had a wrong target.
- upd_dir  in  1  direction-training request.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.
- ras_push  in  1  call resolved; push upd_pc+4 (qualified by upd_en).
- ras_pop  in  1  return resolved; pop (qualified by upd_en).
- ras_count  out  RAS_PTR_W+1  current RAS occupancy, for debug.

Behaviour:
- Reset values:
  - All valid bits 0.
  - RAS pointer 0, ras_count 0.
  - LFSR 8'hA5.
  - All pred_* outputs 0 (fetch_en_r cleared).
- Lookup latency is 1 cycle:
  - fetch_pc is registered when fetch_en=1.
  - Match is combinational on the registered PC against valid entries, comparing tag bits pc[31:2].
  - pred_valid = fetch_en_r & any match.
- Multiple matches: the lowest index wins.
- Prediction per type:
  - cond: taken = counter MSB; target = stored target.
  - jump/call: taken = 1; target = stored target.
  - return: taken = 1 only if ras_count>0; target = RAS top. If the RAS is empty, pred_taken=0 and pred_target = stored target.
- Outputs with pred_valid=0: pred_taken=0; pred_target, pred_index and pred_type are all 0.
- Update is active only when upd_en=1. Priority:
  1. upd_add: write the replacement entry with valid=1, tag, target, type; counter = MSB 1, others 0 (weakly taken).
  2. upd_target_err: rewrite target and type at upd_index; counter reset to weakly taken.
  3. upd_dir with type cond: saturating increment if upd_taken, else saturating decrement (no wrap past all-ones or zero).
- Replacement index:
  - Lowest invalid entry, if any.
  - Else lowest valid entry with counter==0 and type cond.
  - Else lfsr[IDX_W-1:0].
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Steps every cycle when not in reset.
- RAS (circular):
  - Push writes upd_pc[31:2]+1 at the pointer, then the pointer increments modulo RAS_DEPTH.
  - ras_count saturates at RAS_DEPTH. Overflow silently overwrites the oldest entry.
  - Pop on empty is ignored, with no pointer move.
  - Pop otherwise decrements both the pointer and ras_count.
  - Push and pop in the same cycle: push wins, pop dropped.
  - Top = entry at pointer-1, modulo RAS_DEPTH.
- Same-cycle update and lookup: the lookup sees pre-update state. The write is visible to the next registered lookup.
- fetch_en=0 holds fetch_pc_r; pred_valid drops to 0 the following cycle.
- Reset asserted mid-operation clears valids and the RAS in one cycle. Stored data arrays are not cleared.

Decomposition:
- Package btb_pkg:
  - Type encodings BR_COND, BR_JUMP, BR_CALL, BR_RET.
  - LFSR seed and tap constants.
  - Function prio_first(vector) returning the lowest set index, shared by the match and replacement logic.
- One sub-module: ras_circ (RAS storage, pointer, count, push/pop arbitration).

Test Plan:
- Reset, then lookup 0x1C000000 -> pred_valid=0, pred_taken=0, ras_count=0.
- Add cond at pc 0x1C000010, target 0x1C000100.
  - Lookup next cycle -> hit, taken=1, target 0x1C000100, index 0.
  - Two not-taken upd_dir -> counter 00, lookup taken=0.
  - A third not-taken -> counter stays 00.
- Push calls from pc 0x100, 0x200, 0x300; add a return entry at 0x400.
  - Lookup 0x400 -> target 0x304.
  - Pop, lookup again -> target 0x204.
- Push RAS_DEPTH+2 = 10 calls with pc = 0x1000*k -> ras_count=8, top = 0xA004.
  - 8 pops leave count 0.
  - A 9th pop is ignored.
  - Return lookup then gives taken=0.
- Fill all 32 entries; set entry 5 counter to 00 via training; upd_add -> allocated at index 5.
  - With no zero-counter entries, the allocation index equals the LFSR low 5 bits.
- upd_add of pc X in the same cycle as lookup of X -> that lookup misses; the next lookup of X hits.
